// File: rtl/jtag_dtm_tap.sv
// JTAG debug transport front end: oversampled TAP FSM, IR/DR scan chains, DMI request issue.
// TCK edges are seen 3 clocks after the pin. TDO follows tck_fall by 1 clock. A DMI request appears 1 clock after the Update-DR fall.
// dmi_req_* are held stable until dmi_req_ready. A scan that arrives while a request is outstanding is dropped and flagged sticky busy.
module jtag_dtm_tap #(
  parameter int          ABITS  = 7,
  parameter logic [31:0] IDCODE = 32'h00000913
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             jtag_TCK,
  input  logic             jtag_TMS,
  input  logic             jtag_TDI,
  input  logic             jtag_TRSTn,
  output logic             jtag_TDO_data,
  output logic             jtag_TDO_driven,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_resp
);

  localparam int         DRW         = ABITS + 34;
  localparam logic [4:0] IR_IDCODE   = 5'h01;
  localparam logic [4:0] IR_DTMCS    = 5'h10;
  localparam logic [4:0] IR_DMI      = 5'h11;
  localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  tap_state_t state, next_state;

  logic tck_s1, tck_s2, tck_q;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic trst_s1, trst_s2;
  logic tck_rise, tck_fall;

  logic in_tlr, in_cap_dr, in_shift_dr, in_upd_dr, in_cap_ir, in_shift_ir, in_upd_ir;

  logic [4:0]       ir, ir_sr;
  logic [DRW-1:0]   dr_sr, dr_capture, dr_shifted;
  logic             sel_idcode, sel_dtmcs, sel_dmi;

  logic [1:0]       dmistat;
  logic [31:0]      resp_latch;
  logic [ABITS-1:0] last_addr;
  logic             outstanding;

  logic             upd_dtmcs, upd_dmi, cap_dmi, hard_reset_now;
  logic [1:0]       upd_op;

  assign tck_rise = tck_s2 & ~tck_q;
  assign tck_fall = ~tck_s2 & tck_q;

  // Two-flop synchronisers for all pins, plus a delayed TCK copy for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      tck_s1  <= 1'b0; tck_s2  <= 1'b0; tck_q <= 1'b0;
      tms_s1  <= 1'b0; tms_s2  <= 1'b0;
      tdi_s1  <= 1'b0; tdi_s2  <= 1'b0;
      trst_s1 <= 1'b1; trst_s2 <= 1'b1;
    end else begin
      tck_s1  <= jtag_TCK;   tck_s2  <= tck_s1;  tck_q <= tck_s2;
      tms_s1  <= jtag_TMS;   tms_s2  <= tms_s1;
      tdi_s1  <= jtag_TDI;   tdi_s2  <= tdi_s1;
      trst_s1 <= jtag_TRSTn; trst_s2 <= trst_s1;
    end
  end

  // TAP state register; TRSTn low forces Test-Logic-Reset
  always_ff @(posedge clock) begin
    if (reset || !trst_s2) state <= TLR;
    else                   state <= next_state;
  end

  // TAP next state, advanced only on a TCK rising edge
  always_comb begin
    next_state = state;
    if (tck_rise) begin
      case (state)
        TLR:      next_state = tms_s2 ? TLR      : RTI;
        RTI:      next_state = tms_s2 ? SEL_DR   : RTI;
        SEL_DR:   next_state = tms_s2 ? SEL_IR   : CAP_DR;
        CAP_DR:   next_state = tms_s2 ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: next_state = tms_s2 ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: next_state = tms_s2 ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: next_state = tms_s2 ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: next_state = tms_s2 ? UPD_DR   : SHIFT_DR;
        UPD_DR:   next_state = tms_s2 ? SEL_DR   : RTI;
        SEL_IR:   next_state = tms_s2 ? TLR      : CAP_IR;
        CAP_IR:   next_state = tms_s2 ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: next_state = tms_s2 ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: next_state = tms_s2 ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: next_state = tms_s2 ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: next_state = tms_s2 ? UPD_IR   : SHIFT_IR;
        UPD_IR:   next_state = tms_s2 ? SEL_DR   : RTI;
        default:  next_state = TLR;
      endcase
    end
  end

  // State decode used by the scan-chain datapath
  always_comb begin
    in_tlr = 1'b0; in_cap_dr = 1'b0; in_shift_dr = 1'b0; in_upd_dr = 1'b0;
    in_cap_ir = 1'b0; in_shift_ir = 1'b0; in_upd_ir = 1'b0;
    case (state)
      TLR:      in_tlr      = 1'b1;
      CAP_DR:   in_cap_dr   = 1'b1;
      SHIFT_DR: in_shift_dr = 1'b1;
      UPD_DR:   in_upd_dr   = 1'b1;
      CAP_IR:   in_cap_ir   = 1'b1;
      SHIFT_IR: in_shift_ir = 1'b1;
      UPD_IR:   in_upd_ir   = 1'b1;
      default: ;
    endcase
  end

  // Instruction decode, capture values and width-dependent shift insertion point
  always_comb begin
    sel_idcode = (ir == IR_IDCODE);
    sel_dtmcs  = (ir == IR_DTMCS);
    sel_dmi    = (ir == IR_DMI);
    dr_capture = '0;
    dr_shifted = {{(DRW-1){1'b0}}, tdi_s2};
    if (sel_idcode) begin
      dr_capture = {{(DRW-32){1'b0}}, IDCODE};
      dr_shifted = {{(DRW-32){1'b0}}, tdi_s2, dr_sr[31:1]};
    end else if (sel_dtmcs) begin
      dr_capture = {{(DRW-32){1'b0}}, 14'b0, 2'b0, 1'b0, 3'd1, dmistat, ABITS_FIELD, 4'd1};
      dr_shifted = {{(DRW-32){1'b0}}, tdi_s2, dr_sr[31:1]};
    end else if (sel_dmi) begin
      dr_capture = {last_addr, resp_latch, outstanding ? 2'd3 : dmistat};
      dr_shifted = {tdi_s2, dr_sr[DRW-1:1]};
    end
  end

  assign upd_dtmcs      = tck_fall && in_upd_dr && sel_dtmcs;
  assign upd_dmi        = tck_fall && in_upd_dr && sel_dmi;
  assign cap_dmi        = tck_rise && in_cap_dr && sel_dmi;
  assign hard_reset_now = upd_dtmcs && dr_sr[17];
  assign upd_op         = dr_sr[1:0];

  // Instruction register: capture/shift on TCK rise, commit on the Update-IR fall
  always_ff @(posedge clock) begin
    if (reset) begin
      ir    <= IR_IDCODE;
      ir_sr <= 5'b0;
    end else begin
      if (!trst_s2 || in_tlr)            ir <= IR_IDCODE;
      else if (tck_fall && in_upd_ir)    ir <= ir_sr;
      if (tck_rise && in_cap_ir)         ir_sr <= 5'b00001;
      else if (tck_rise && in_shift_ir)  ir_sr <= {tdi_s2, ir_sr[4:1]};
    end
  end

  // Shared data register shift chain
  always_ff @(posedge clock) begin
    if (reset)                         dr_sr <= '0;
    else if (tck_rise && in_cap_dr)    dr_sr <= dr_capture;
    else if (tck_rise && in_shift_dr)  dr_sr <= dr_shifted;
  end

  // TDO presents the chain LSB on each TCK fall while shifting
  always_ff @(posedge clock) begin
    if (reset) begin
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else if (!trst_s2) begin
      jtag_TDO_driven <= 1'b0;
    end else if (tck_fall) begin
      if (in_shift_ir) begin
        jtag_TDO_data   <= ir_sr[0];
        jtag_TDO_driven <= 1'b1;
      end else if (in_shift_dr) begin
        jtag_TDO_data   <= dr_sr[0];
        jtag_TDO_driven <= 1'b1;
      end else begin
        jtag_TDO_driven <= 1'b0;
      end
    end
  end

  // DMI request/response tracking and sticky status; later statements take priority
  always_ff @(posedge clock) begin
    if (reset) begin
      dmi_req_valid <= 1'b0;
      dmi_req_addr  <= '0;
      dmi_req_data  <= '0;
      dmi_req_op    <= '0;
      dmistat       <= 2'd0;
      resp_latch    <= '0;
      last_addr     <= '0;
      outstanding   <= 1'b0;
    end else begin
      if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
      if (dmi_resp_valid && outstanding && !hard_reset_now) begin
        outstanding <= 1'b0;
        resp_latch  <= dmi_resp_data;
        if (dmi_resp_resp != 2'd0 && dmistat != 2'd3) dmistat <= 2'd2;
      end
      if (cap_dmi && outstanding) dmistat <= 2'd3;
      if (upd_dtmcs) begin
        if (dr_sr[16]) dmistat <= 2'd0;
        if (dr_sr[17]) begin
          dmistat       <= 2'd0;
          dmi_req_valid <= 1'b0;
          outstanding   <= 1'b0;
        end
      end
      if (upd_dmi) begin
        if (dmistat != 2'd0 || outstanding) begin
          if (outstanding) dmistat <= 2'd3;
        end else if (upd_op == 2'd1 || upd_op == 2'd2) begin
          dmi_req_addr  <= dr_sr[DRW-1:34];
          dmi_req_data  <= dr_sr[33:2];
          dmi_req_op    <= upd_op;
          dmi_req_valid <= 1'b1;
          outstanding   <= 1'b1;
          last_addr     <= dr_sr[DRW-1:34];
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Bench for jtag_dtm_tap: drives JTAG pins with slow TCK and checks scans and DMI traffic.
// Expected scan results and DMI requests are queued when driven and compared when seen.
// dmi_req_ready is driven by the bench to exercise holding and acceptance.
module tb_jtag_dtm_tap;

  logic        clock = 1'b0;
  logic        reset;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic        jtag_TDO_data, jtag_TDO_driven;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_resp_valid;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_resp;

  int errors = 0;
  int checks = 0;

  logic [40:0] scan_q[$];
  logic [40:0] req_q[$];

  typedef struct {
    logic [4:0]  ir;
    int          n;
    logic [40:0] tdi;
    logic [40:0] exp;
  } vec_t;

  vec_t vecs[4];

  jtag_dtm_tap dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [40:0] got, input logic [40:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Accepted DMI requests are compared against the queue of expected requests
  always @(negedge clock) begin
    if (!reset && dmi_req_valid && dmi_req_ready) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got=%h expected=none", {dmi_req_addr, dmi_req_data, dmi_req_op});
      end else begin
        logic [40:0] e;
        e = req_q.pop_front();
        chk("dmi_req", {dmi_req_addr, dmi_req_data, dmi_req_op}, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // One full TCK period; TDO is sampled just before the rising edge
  task automatic tck(input logic tms, input logic tdi, output logic tdo, output logic drv);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    repeat (4) @(posedge clock);
    #1;
    tdo = jtag_TDO_data;
    drv = jtag_TDO_driven;
    jtag_TCK = 1'b1;
    repeat (4) @(posedge clock);
    #1 jtag_TCK = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  // From Run-Test-Idle, load an instruction and return to Run-Test-Idle
  task automatic load_ir(input logic [4:0] val);
    logic tdo, drv;
    logic [40:0] got;
    got = '0;
    tck(1'b1, 1'b0, tdo, drv);
    tck(1'b1, 1'b0, tdo, drv);
    tck(1'b0, 1'b0, tdo, drv);
    tck(1'b0, 1'b0, tdo, drv);
    for (int i = 0; i < 5; i++) begin
      tck(i == 4, val[i], tdo, drv);
      got[i] = tdo;
    end
    tck(1'b1, 1'b0, tdo, drv);
    tck(1'b0, 1'b0, tdo, drv);
    chk($sformatf("ir_capture_%h", val), got, 41'h01);
  endtask

  // From Run-Test-Idle, scan n DR bits LSB-first and return to Run-Test-Idle
  task automatic scan_dr(input int n, input logic [40:0] tdi_v, input logic [40:0] exp, input string name);
    logic tdo, drv;
    logic drv_bad;
    logic [40:0] got, e;
    got = '0;
    drv_bad = 1'b0;
    scan_q.push_back(exp);
    tck(1'b1, 1'b0, tdo, drv); if (drv) drv_bad = 1'b1;
    tck(1'b0, 1'b0, tdo, drv); if (drv) drv_bad = 1'b1;
    tck(1'b0, 1'b0, tdo, drv); if (drv) drv_bad = 1'b1;
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, tdi_v[i], tdo, drv);
      got[i] = tdo;
      if (!drv) drv_bad = 1'b1;
    end
    tck(1'b1, 1'b0, tdo, drv); if (drv) drv_bad = 1'b1;
    tck(1'b0, 1'b0, tdo, drv); if (drv) drv_bad = 1'b1;
    e = scan_q.pop_front();
    chk(name, got, e);
    chk({name, "_driven"}, {40'b0, drv_bad}, 41'b0);
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] resp);
    dmi_resp_data  = data;
    dmi_resp_resp  = resp;
    dmi_resp_valid = 1'b1;
    @(posedge clock);
    #1 dmi_resp_valid = 1'b0;
  endtask

  initial begin
    logic tdo, drv;
    vecs[0] = '{ir: 5'h01, n: 32, tdi: 41'h0,  exp: 41'h00000913};
    vecs[1] = '{ir: 5'h10, n: 32, tdi: 41'h0,  exp: 41'h00001071};
    vecs[2] = '{ir: 5'h05, n: 8,  tdi: 41'hB2, exp: 41'h64};
    vecs[3] = '{ir: 5'h1F, n: 8,  tdi: 41'h5A, exp: 41'hB4};

    reset = 1'b1;
    jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0; dmi_resp_resp = '0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_tdo", {39'b0, jtag_TDO_data, jtag_TDO_driven}, 41'b0);
    chk("reset_req", {dmi_req_addr, dmi_req_data, dmi_req_op}, 41'b0);
    chk("reset_vld", {40'b0, dmi_req_valid}, 41'b0);

    // Walk to Test-Logic-Reset then Run-Test-Idle; IDCODE must be selected without loading IR
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, tdo, drv);
    tck(1'b0, 1'b0, tdo, drv);
    scan_dr(32, 41'h0, 41'h00000913, "idcode_default");

    for (int i = 0; i < 4; i++) begin
      load_ir(vecs[i].ir);
      scan_dr(vecs[i].n, vecs[i].tdi, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // DMI write request held while not ready, released one cycle after ready
    load_ir(5'h11);
    req_q.push_back({7'h10, 32'hDEADBEEF, 2'd2});
    scan_dr(41, {7'h10, 32'hDEADBEEF, 2'd2}, 41'h0, "dmi_first_capture");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_vld", {40'b0, dmi_req_valid}, 41'b1);
      chk("hold_fields", {dmi_req_addr, dmi_req_data, dmi_req_op}, {7'h10, 32'hDEADBEEF, 2'd2});
    end
    @(posedge clock);
    #1 dmi_req_ready = 1'b1;
    @(posedge clock);
    #1 dmi_req_ready = 1'b0;
    @(negedge clock);
    chk("vld_drop", {40'b0, dmi_req_valid}, 41'b0);
    @(posedge clock);
    #1;

    respond(32'h12345678, 2'd0);
    scan_dr(41, 41'h0, {7'h10, 32'h12345678, 2'd0}, "dmi_resp_capture");

    // A response with nothing outstanding must not touch the latch or status
    respond(32'hAAAA5555, 2'd3);
    scan_dr(41, 41'h0, {7'h10, 32'h12345678, 2'd0}, "dmi_stray_resp");

    // Overlapping scan while a read is outstanding: dropped, sticky busy
    dmi_req_ready = 1'b1;
    req_q.push_back({7'h22, 32'h0, 2'd1});
    scan_dr(41, {7'h22, 32'h0, 2'd1}, {7'h10, 32'h12345678, 2'd0}, "dmi_read_issue");
    scan_dr(41, {7'h33, 32'h0000FFFF, 2'd2}, {7'h22, 32'h12345678, 2'd3}, "dmi_busy_capture");
    scan_dr(41, 41'h0, {7'h22, 32'h12345678, 2'd3}, "dmi_busy_again");
    load_ir(5'h10);
    scan_dr(32, 41'h10000, 41'h00001C71, "dtmcs_busy");
    scan_dr(32, 41'h0, 41'h00001071, "dtmcs_after_dmireset");
    scan_dr(32, 41'h20000, 41'h00001071, "dtmcs_hardreset");
    load_ir(5'h11);
    scan_dr(41, 41'h0, {7'h22, 32'h12345678, 2'd0}, "dmi_after_hardreset");

    // Error response sets dmistat=2 until dmireset
    req_q.push_back({7'h05, 32'h00000001, 2'd2});
    scan_dr(41, {7'h05, 32'h00000001, 2'd2}, {7'h22, 32'h12345678, 2'd0}, "dmi_err_issue");
    respond(32'h00000BAD, 2'd2);
    load_ir(5'h10);
    scan_dr(32, 41'h0, 41'h00001871, "dtmcs_err");
    scan_dr(32, 41'h10000, 41'h00001871, "dtmcs_err_clear");
    scan_dr(32, 41'h0, 41'h00001071, "dtmcs_err_cleared");
    load_ir(5'h11);
    scan_dr(41, 41'h0, {7'h05, 32'h00000BAD, 2'd0}, "dmi_err_latch");

    // TRSTn in the middle of Shift-DR
    load_ir(5'h10);
    tck(1'b1, 1'b0, tdo, drv);
    tck(1'b0, 1'b0, tdo, drv);
    tck(1'b0, 1'b0, tdo, drv);
    tck(1'b0, 1'b0, tdo, drv);
    chk("trst_pre_driven", {40'b0, drv}, 41'b1);
    jtag_TRSTn = 1'b0;
    repeat (4) @(posedge clock);
    #1 jtag_TRSTn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("trst_driven", {40'b0, jtag_TDO_driven}, 41'b0);
    tck(1'b0, 1'b0, tdo, drv);
    scan_dr(32, 41'h0, 41'h00000913, "trst_idcode");

    repeat (10) @(posedge clock);
    #1;
    chk("req_queue_empty", 41'(req_q.size()), 41'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
